// File: rtl/ines_pkg.sv
// ines_pkg: shared state codes, error codes, mapper_flags layout and page sizes for the iNES loader.
package ines_pkg;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HEADER  = 3'd1;
   localparam logic [2:0] ST_TRAINER = 3'd2;
   localparam logic [2:0] ST_PRG     = 3'd3;
   localparam logic [2:0] ST_CHR     = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;
   localparam logic [2:0] ST_ERROR   = 3'd6;
   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_MAGIC   = 3'd1;
   localparam logic [2:0] ERR_PRG     = 3'd2;
   localparam logic [2:0] ERR_EXP     = 3'd3;
   localparam logic [2:0] ERR_CHR     = 3'd4;
   localparam logic [2:0] ERR_TRAINER = 3'd5;
   localparam int MF_MAPPER  = 0;
   localparam int MF_PRG     = 12;
   localparam int MF_CHR     = 16;
   localparam int MF_MIRROR  = 20;
   localparam int MF_CHR_RAM = 21;
   localparam int MF_FOUR    = 22;
   localparam int MF_SUB     = 28;
   localparam logic [31:0] PRG_PAGE_BYTES = 32'd16384;
   localparam logic [31:0] CHR_PAGE_BYTES = 32'd8192;
   localparam logic [31:0] TRAINER_BYTES  = 32'd512;
   localparam logic [31:0] INES_MAGIC     = 32'h1A53454E;
   // ceil(log2(pages)); 0 and 1 page both encode as 0
   function automatic logic [3:0] size_code(input logic [11:0] pages);
      logic [11:0] m;
      m = pages - 12'd1;
      size_code = 4'd0;
      if (pages > 12'd1)
         for (int i = 0; i < 12; i++)
            if (m[i]) size_code = 4'(i + 1);
   endfunction
endpackage

// File: rtl/ines_hdr_decode.sv
// ines_hdr_decode: combinational decode of the 16-byte iNES header (version, sizes, mapper, legality).
// INES_LOADER_TRAINER_EN makes a trainer legal; otherwise it is reported as an error.
module ines_hdr_decode
   import ines_pkg::*;
#(
   parameter int ADDR_W = 22,
   parameter logic [ADDR_W-1:0] PRG_BASE = '0,
   parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000,
   parameter logic [ADDR_W-1:0] TRAINER_BASE = 22'h3FFE00
) (
   input  logic [127:0] hdr,
   input  logic         invert_mirroring,
   output logic [11:0]  prg_pages,
   output logic [11:0]  chr_pages,
   output logic [2:0]   err_code,
   output logic [31:0]  flags
);
   logic [7:0] b4, b5, b6, b7, b8, b9;
   logic nes2, dirty, exp_form, trainer_err, unused_bits;
   logic [31:0] prg_bytes, chr_bytes;
   logic [11:0] mapper;
   assign {b9, b8, b7, b6, b5, b4} = hdr[79:32];
   assign nes2 = b7[3:2] == 2'b10;
   assign dirty = |hdr[127:64];
   assign prg_pages = {nes2 ? b9[3:0] : 4'h0, b4};
   assign chr_pages = {nes2 ? b9[7:4] : 4'h0, b5};
   assign exp_form = nes2 && (b9[3:0] == 4'hF || b9[7:4] == 4'hF);
   assign prg_bytes = 32'(prg_pages) * PRG_PAGE_BYTES;
   assign chr_bytes = 32'(chr_pages) * CHR_PAGE_BYTES;
`ifdef INES_LOADER_TRAINER_EN
   assign trainer_err = 1'b0;
`else
   assign trainer_err = b6[2];
`endif
   assign unused_bits = ^{b6[2:1], b7[1:0]};
   assign err_code = hdr[31:0] != INES_MAGIC ? ERR_MAGIC
      : exp_form ? ERR_EXP
      : (prg_pages == 12'd0 || prg_bytes > 32'(CHR_BASE - PRG_BASE)) ? ERR_PRG
      : chr_bytes > 32'(TRAINER_BASE - CHR_BASE) ? ERR_CHR
      : trainer_err ? ERR_TRAINER : ERR_NONE;
   // dirty iNES1 headers carry junk in byte 7's upper nibble
   assign mapper = {nes2 ? b8[3:0] : 4'h0, (dirty && !nes2) ? 4'h0 : b7[7:4], b6[7:4]};
   always_comb begin
      flags = '0;
      flags[MF_MAPPER +: 12] = mapper;
      flags[MF_PRG +: 4] = size_code(prg_pages);
      flags[MF_CHR +: 4] = size_code(chr_pages);
      flags[MF_MIRROR] = b6[0] ^ invert_mirroring;
      flags[MF_CHR_RAM] = chr_pages == 12'd0;
      flags[MF_FOUR] = b6[3];
      flags[MF_SUB +: 4] = nes2 ? b8[7:4] : 4'h0;
   end
endmodule

// File: rtl/ines_loader.sv
// ines_loader: streams an iNES image into memory through a one-entry write register.
// INES_LOADER_TRAINER_EN enables loading the 512-byte trainer at TRAINER_BASE.
module ines_loader
   import ines_pkg::*;
#(
   parameter int ADDR_W = 22,
   parameter logic [ADDR_W-1:0] PRG_BASE = '0,
   parameter logic [ADDR_W-1:0] CHR_BASE = 22'h200000,
   parameter logic [ADDR_W-1:0] TRAINER_BASE = 22'h3FFE00
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              invert_mirroring,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_wait,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   input  logic              mem_ack,
   output logic [31:0]       mapper_flags,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code
);
   logic [2:0] state;
   logic [127:0] hdr, hdr_in;
   logic [3:0] idx;
   logic [ADDR_W:0] cnt, prg_len, chr_len;
   logic [ADDR_W-1:0] ptr;
   logic [11:0] prg_pages, chr_pages;
   logic [2:0] hdr_err;
   logic [31:0] flags;
   logic accept, payload, last;
   assign in_wait = mem_wr;
   assign accept = in_valid && !mem_wr;
   assign payload = state == ST_TRAINER || state == ST_PRG || state == ST_CHR;
   assign last = cnt == '0;
   assign busy = payload || state == ST_HEADER || mem_wr;
   assign done = state == ST_DONE;
   assign error = state == ST_ERROR;
   // byte 15 is decoded in the same cycle it arrives
   assign hdr_in = state == ST_HEADER ? {in_data, hdr[127:8]} : hdr;
   assign prg_len = (ADDR_W+1)'(32'(prg_pages) * PRG_PAGE_BYTES - 32'd1);
   assign chr_len = (ADDR_W+1)'(32'(chr_pages) * CHR_PAGE_BYTES - 32'd1);
   ines_hdr_decode #(
      .ADDR_W(ADDR_W), .PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE), .TRAINER_BASE(TRAINER_BASE)
   ) u_hdr (
      .hdr(hdr_in), .invert_mirroring(invert_mirroring), .prg_pages(prg_pages),
      .chr_pages(chr_pages), .err_code(hdr_err), .flags(flags)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         hdr <= '0;
         idx <= '0;
         cnt <= '0;
         ptr <= '0;
         mem_wr <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         err_code <= ERR_NONE;
         mapper_flags <= '0;
      end else if (start) begin
         state <= ST_HEADER;
         idx <= '0;
         cnt <= '0;
         mem_wr <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         if (mem_wr && mem_ack) mem_wr <= 1'b0;
         if (accept && payload) begin
            mem_wr <= 1'b1;
            mem_addr <= ptr;
            mem_data <= in_data;
            ptr <= ptr + ADDR_W'(1);
            cnt <= cnt - (ADDR_W+1)'(1);
         end
         if (accept) begin
            case (state)
               ST_HEADER: begin
                  hdr <= hdr_in;
                  idx <= idx + 4'd1;
                  if (idx == 4'd15) begin
                     if (hdr_err != ERR_NONE) begin
                        state <= ST_ERROR;
                        err_code <= hdr_err;
                     end
`ifdef INES_LOADER_TRAINER_EN
                     else if (hdr_in[50]) begin
                        state <= ST_TRAINER;
                        cnt <= (ADDR_W+1)'(TRAINER_BYTES - 32'd1);
                        ptr <= TRAINER_BASE;
                     end
`endif
                     else begin
                        state <= ST_PRG;
                        cnt <= prg_len;
                        ptr <= PRG_BASE;
                     end
                  end
               end
`ifdef INES_LOADER_TRAINER_EN
               ST_TRAINER: if (last) begin
                  state <= ST_PRG;
                  cnt <= prg_len;
                  ptr <= PRG_BASE;
               end
`endif
               ST_PRG: if (last) begin
                  state <= chr_pages == 12'd0 ? ST_DONE : ST_CHR;
                  cnt <= chr_len;
                  ptr <= CHR_BASE;
                  if (chr_pages == 12'd0) mapper_flags <= flags;
               end
               ST_CHR: if (last) begin
                  state <= ST_DONE;
                  mapper_flags <= flags;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ines_loader.sv
// tb_ines_loader: directed checks of header decode, error codes, write handshake, abort and a full load.
module tb_ines_loader;
   import ines_pkg::*;
   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, invert_mirroring = 1'b0;
   logic in_valid = 1'b0, mem_ack = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic in_wait, mem_wr, busy, done, error;
   logic [21:0] mem_addr;
   logic [7:0] mem_data;
   logic [31:0] mapper_flags;
   logic [2:0] err_code;
   int checks = 0, passed = 0;
   int wr_total = 0, wr_bad = 0, mon_base = 0, k, stable, trn_bad, wr_mark;
   logic mon_en = 1'b0;
   logic [21:0] ea;
   logic [7:0] h [16];
   typedef struct packed {
      logic [7:0] b0, b4, b5, b6, b7, b9;
      logic [2:0] err;
   } vec_t;
`ifdef INES_LOADER_TRAINER_EN
   localparam logic [2:0] TRN_ERR = 3'd0;
`else
   localparam logic [2:0] TRN_ERR = 3'd5;
`endif
   localparam vec_t VECS [7] = '{
      '{8'h4E, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 3'd0},
      '{8'h4E, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, TRN_ERR},
      '{8'h4E, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd2},
      '{8'h4E, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 3'd2},
      '{8'h4E, 8'h01, 8'h00, 8'h00, 8'h08, 8'h0F, 3'd3},
      '{8'h4E, 8'h01, 8'h00, 8'h00, 8'h08, 8'h10, 3'd4},
      '{8'h4D, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1}
   };
   always #5 clk = ~clk;
   ines_loader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .invert_mirroring(invert_mirroring),
      .in_valid(in_valid), .in_data(in_data), .in_wait(in_wait), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack), .mapper_flags(mapper_flags),
      .busy(busy), .done(done), .error(error), .err_code(err_code)
   );
   function automatic logic [7:0] pat(input int i);
      return 8'(i ^ (i >> 8)) ^ 8'hA5;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   always @(negedge clk)
      if (mem_wr && mem_ack) begin
         k = wr_total - mon_base;
         ea = k < 32768 ? 22'(k) : 22'h200000 + 22'(k - 32768);
         if (mon_en && (mem_addr !== ea || mem_data !== pat(k))) wr_bad++;
         wr_total++;
      end
   task automatic send(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      while (in_wait) begin
         t++;
         if (t > 200) begin
            $display("FAIL send_timeout: in_wait stuck at 1, expected 0");
            $fatal(1, "input stalled");
         end
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = b;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask
   task automatic set_hdr(input logic [7:0] b0, b4, b5, b6, b7, b8, b9, b15);
      h = '{b0, 8'h45, 8'h53, 8'h1A, b4, b5, b6, b7, b8, b9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, b15};
   endtask
   task automatic send_hdr();
      for (int i = 0; i < 16; i++) send(h[i]);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_in_wait", in_wait, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_code", err_code, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_flags", mapper_flags, 0);
      reset_n = 1'b1;
      send(8'hFF);
      send(8'h4E);
      check("idle_discard", wr_total, 0);
      check("idle_busy", busy, 0);
      for (int i = 0; i < 7; i++) begin
         pulse_start();
         set_hdr(VECS[i].b0, VECS[i].b4, VECS[i].b5, VECS[i].b6, VECS[i].b7, 8'h00, VECS[i].b9, 8'h00);
         send_hdr();
         check($sformatf("vec%0d_err_code", i), err_code, VECS[i].err);
         check($sformatf("vec%0d_error", i), error, VECS[i].err != 3'd0);
         check($sformatf("vec%0d_busy", i), busy, VECS[i].err == 3'd0);
      end
      repeat (3) send(8'h5A);
      check("error_discard_no_wr", wr_total, 0);
      check("error_in_wait", in_wait, 0);
      check("error_held", error, 1);
      pulse_start();
      check("start_clr_error", error, 0);
      check("start_clr_code", err_code, 0);
      check("start_busy", busy, 1);
      set_hdr(8'h4E, 8'h01, 8'h00, 8'h40, 8'h08, 8'h01, 8'h00, 8'h00);
      send_hdr();
      check("nes2_mapper", dut.u_hdr.flags[11:0], 12'h104);
      send(8'h11);
      send(8'h22);
      @(posedge clk);
      #1 mem_ack = 1'b0;
      send(8'h33);
      check("abort_pre_wr", mem_wr, 1);
      check("abort_pre_addr", mem_addr, 2);
      check("abort_pre_data", mem_data, 8'h33);
      pulse_start();
      check("abort_wr_drop", mem_wr, 0);
      check("abort_state", dut.state, ST_HEADER);
      check("abort_done", done, 0);
      mem_ack = 1'b1;
      set_hdr(8'h4E, 8'h01, 8'h00, 8'h40, 8'h30, 8'h00, 8'h00, 8'h00);
      send_hdr();
      check("ines1_clean_mapper", dut.u_hdr.flags[11:0], 12'h034);
      pulse_start();
      set_hdr(8'h4E, 8'h01, 8'h00, 8'h40, 8'h00, 8'h01, 8'h00, 8'h01);
      send_hdr();
      check("ines1_dirty_mapper", dut.u_hdr.flags[11:0], 12'h004);
      pulse_start();
      set_hdr(8'h4E, 8'h01, 8'h00, 8'h40, 8'h30, 8'h01, 8'h00, 8'h01);
      send_hdr();
      check("ines1_dirty_forced", dut.u_hdr.flags[11:0], 12'h004);
`ifdef INES_LOADER_TRAINER_EN
      pulse_start();
      set_hdr(8'h4E, 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
      send_hdr();
      trn_bad = 0;
      for (int i = 0; i < 512; i++) begin
         send(8'(i));
         if (mem_addr !== 22'h3FFE00 + 22'(i) || mem_data !== 8'(i)) trn_bad++;
      end
      check("trainer_addr_bad", trn_bad, 0);
      send(8'hC3);
      check("trainer_then_prg_addr", mem_addr, 0);
      check("trainer_then_prg_data", mem_data, 8'hC3);
`endif
      pulse_start();
      set_hdr(8'h4E, 8'h02, 8'h01, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00);
      send_hdr();
      check("full_busy", busy, 1);
      mon_base = wr_total;
      mon_en = 1'b1;
      mem_ack = 1'b0;
      send(pat(0));
      stable = 0;
      repeat (10) begin
         @(negedge clk);
         if (in_wait && mem_wr && mem_addr == 22'h0 && mem_data == pat(0)) stable++;
      end
      check("stall_hold", stable, 10);
      @(posedge clk);
      #1 mem_ack = 1'b1;
      for (int i = 1; i < 40960; i++) send(pat(i));
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      check("full_wr_count", wr_total - mon_base, 40960);
      check("full_wr_bad", wr_bad, 0);
      check("full_done", done, 1);
      check("full_busy_clear", busy, 0);
      check("full_error", error, 0);
      check("full_flags", mapper_flags, 32'h0010_1004);
      check("full_prg_size", mapper_flags[15:12], 1);
      check("full_chr_size", mapper_flags[19:16], 0);
      wr_mark = wr_total;
      send(8'h99);
      send(8'h98);
      repeat (2) @(negedge clk);
      check("done_discard", wr_total - wr_mark, 0);
      check("done_held", done, 1);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/ines_loader.md
INES_LOADER -- requirements
Module: ines_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, memory byte-address width.
REQ-002 SHALL have parameter PRG_BASE, default 0, first PRG byte address.
REQ-003 SHALL have parameter CHR_BASE, default 22'h200000, first CHR byte address.
REQ-004 SHALL have parameter TRAINER_BASE, default 22'h3FFE00, trainer load address.
REQ-005 SHALL have ports: clk in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start in 1, one-cycle pulse that restarts parsing; invert_mirroring in 1, OSD mirroring flip.
REQ-007 SHALL have ports: in_valid in 1, input byte strobe; in_data in 8, input byte; in_wait out 1, upstream must hold byte.
REQ-008 SHALL have ports: mem_wr out 1, write request; mem_addr out ADDR_W; mem_data out 8; mem_ack in 1, write accepted.
REQ-009 SHALL have ports: mapper_flags out 32; busy out 1; done out 1; error out 1; err_code out 3.

Function
REQ-010 SHALL accept a byte only when in_valid=1 and in_wait=0.
REQ-011 SHALL drive in_wait = mem_wr (registered); the one-entry output register is the only buffer.
REQ-012 SHALL assert mem_wr the cycle after a payload byte is accepted; mem_addr/mem_data SHALL hold until the cycle mem_ack=1, then mem_wr SHALL drop next cycle.
REQ-013 SHALL use states IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR; start from any state -> HEADER, clearing done/error/counters.
REQ-014 HEADER SHALL capture 16 bytes; after byte 15: check "NES\x1A" and size legality, then -> TRAINER (flags6[2]=1), PRG (prg>0), or ERROR.
REQ-015 SHALL detect iNES 2.0 when flags7[3:2]=2'b10; else if bytes 8..15 nonzero (dirty) mapper[7:4] SHALL be forced 0.
REQ-016 PRG pages SHALL be {flags9[3:0],byte4} (iNES 2.0) or byte4; CHR pages {flags9[7:4],byte5} or byte5; exponent form (MSB nibble 4'hF) SHALL be error code 3.
REQ-017 SHALL set err_code: 1 bad magic, 2 PRG size exceeds CHR_BASE-PRG_BASE or is zero, 3 exponent size, 4 CHR exceeds TRAINER_BASE-CHR_BASE, 5 trainer without TRAINER support.
REQ-018 SHALL count bytes with a down-counter of ADDR_W+1 bits; PRG = pages*16384, CHR = pages*8192, trainer = 512.
REQ-019 SHALL go TRAINER -> PRG -> CHR (skipped when CHR pages=0) -> DONE, each transition when the counter reaches 0 on an accepted byte, reloading mem_addr base.
REQ-020 DONE SHALL assert done=1, publish mapper_flags; bytes arriving in DONE/ERROR/IDLE SHALL be accepted and discarded.
REQ-021 mapper_flags SHALL be {submapper[3:0], 5'b0, flags6[3] four-screen, chr_ram, flags6[0]^invert_mirroring, chr_size[3:0], prg_size[3:0], mapper[11:0]}; size codes = ceil(log2(pages)) saturating at 15; mapper[11:8]=byte8[3:0] only in iNES 2.0.
REQ-022 busy SHALL be 1 in HEADER/TRAINER/PRG/CHR, or while mem_wr=1.
REQ-023 start coincident with mem_wr=1 SHALL abandon the pending write (mem_wr drops next cycle).

Reset
REQ-024 On reset_n=0 SHALL asynchronously enter IDLE; mem_wr, in_wait, busy, done, error=0; err_code=0; mem_addr=0; mapper_flags=0.

Configuration
REQ-025 With INES_LOADER_TRAINER_EN defined SHALL load trainer bytes to TRAINER_BASE..+511; without it, flags6[2]=1 SHALL give ERROR, err_code 5, and no TRAINER state logic.

Structure
REQ-026 State enum, err_code values, mapper_flags field offsets and page-size constants SHALL live in package ines_pkg.
REQ-027 Header decode (iNES version, sizes, mapper, legality) SHALL be sub-module ines_hdr_decode, combinational over the 16 header bytes.

Verification
REQ-028 iNES1, 2 PRG/1 CHR, mem_ack always 1 -> 32768 writes at 0.., 8192 at 22'h200000, done=1, prg_size=1, chr_size=0.
REQ-029 Header byte0=8'h4D -> ERROR, err_code=1, no mem_wr ever.
REQ-030 mem_ack held 0 for 10 cycles on first PRG write -> in_wait=1 10 cycles, address/data stable, no byte lost.
REQ-031 iNES 2.0, byte8=8'h01, byte6=8'h40 -> mapper_flags[11:0]=12'h104; dirty iNES1 same bytes with byte15=1 -> 12'h004.
REQ-032 flags6=8'h04: with macro, 512 writes at 22'h3FFE00 before PRG; without, err_code=5.
REQ-033 start pulse mid-PRG with mem_wr=1 -> mem_wr=0 next cycle, state HEADER, done=0.
